// File: rtl/img_ram_arb.sv
// Arbiter for the single-port image RAM (UART writer > inference reader > display
// reader), plus the IDLE -> GO -> INFER sequencer for each inference run.
module img_ram_arb #(
   parameter int          RAM_DEPTH = 784,
   parameter int          AW        = 10,
   parameter int          DW        = 8,
   parameter int          RD_LAT    = 1,
   parameter logic [23:0] TIMEOUT   = 24'd983040
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          frame_start,
   input  logic          inf_req,
   input  logic [AW-1:0] inf_addr,
   output logic          inf_gnt,
   output logic          inf_rvalid,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_gnt,
   output logic          disp_rvalid,
   output logic [DW-1:0] rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          infer_go,
   input  logic          infer_done,
   output logic          infer_busy,
   output logic [2:0]    err_flags
);

   typedef enum logic [1:0] {IDLE, GO, INFER} state_t;

   // Owner of a read in flight; oor reads return zero instead of RAM data.
   typedef struct packed {
      logic inf;
      logic disp;
      logic oor;
   } tag_t;

   localparam logic [AW:0] DEPTH = (AW+1)'(RAM_DEPTH);

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic [23:0] cnt_q, cnt_d;
   logic [2:0]  err_q, err_d;
   tag_t        tag_q [RD_LAT];
   tag_t        tag_d [RD_LAT];

   logic          timeout_ev;
   logic          wr_act;
   logic          wr_oor;
   logic          rd_oor;
   logic [AW-1:0] rd_addr;
   logic [2:0]    err_set;
   tag_t          push;
   tag_t          tail;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      cnt_d      = '0;
      timeout_ev = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_start) state_d = GO;
         end
         GO: begin
            state_d = INFER;
            if (frame_start) pending_d = 1'b1;
         end
         INFER: begin
            cnt_d = cnt_q + 24'd1;
            if (frame_start) pending_d = 1'b1;
            if (infer_done) begin
               if (pending_q || frame_start) begin
                  state_d   = GO;
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (cnt_q == TIMEOUT - 24'd1) begin
               state_d    = IDLE;
               pending_d  = 1'b0;
               timeout_ev = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grants are gated by rst so nothing enters the read pipeline during reset.
   always_comb begin
      wr_act    = wr_en && !rst;
      wr_oor    = {1'b0, wr_addr} >= DEPTH;
      inf_gnt   = !rst && !wr_en && inf_req && (state_q == INFER);
      disp_gnt  = !rst && !wr_en && disp_req && !inf_gnt;
      rd_addr   = inf_gnt ? inf_addr : disp_addr;
      rd_oor    = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      push      = '0;
      if (wr_act) begin
         ram_en    = !wr_oor;
         ram_we    = !wr_oor;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end else if (inf_gnt || disp_gnt) begin
         rd_oor    = {1'b0, rd_addr} >= DEPTH;
         ram_en    = !rd_oor;
         ram_addr  = rd_addr;
         push.inf  = inf_gnt;
         push.disp = disp_gnt;
         push.oor  = rd_oor;
      end
   end

   always_comb begin
      tag_d[0] = push;
      for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
   end

   always_comb begin
      err_set[0] = wr_act && (state_q != IDLE);
      err_set[1] = (wr_act && wr_oor) || rd_oor;
      err_set[2] = timeout_ev;
      err_d      = frame_start ? 3'b000 : (err_q | err_set);
   end

   // NOTE: non-blocking assignments in clocked blocks so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= '0;
         // NOTE: unlike a data RAM, this tag pipeline must be reset: a stale
         // tag would raise an rvalid for a read that was never granted.
         tag_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         tag_q     <= tag_d;
      end
   end

   assign tail        = tag_q[RD_LAT-1];
   assign inf_rvalid  = tail.inf;
   assign disp_rvalid = tail.disp;
   assign rdata       = ((tail.inf || tail.disp) && !tail.oor) ? ram_rdata : '0;
   assign infer_go    = (state_q == GO);
   assign infer_busy  = (state_q != IDLE);
   assign err_flags   = err_q;

endmodule
